// File: rtl/afifo_rd_master.sv
// Read-domain burst master: pops the async FIFO onto a valid/ready stream with empty-retry timeout.
// Defining AFIFO_RD_STATS_EN adds saturating pop / empty-cycle / timeout counters.
module afifo_rd_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int BURST_WIDTH     = 8,
  parameter int MAX_EMPTY_RETRY = 10
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [BURST_WIDTH-1:0] cmd_len,
  input  logic                   cmd_inject,
  output logic                   rinc,
  input  logic                   rempty,
  input  logic [DATA_WIDTH-1:0]  rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic                   done,
  output logic [1:0]             status
`ifdef AFIFO_RD_STATS_EN
  ,
  output logic [31:0]            stat_words,
  output logic [31:0]            stat_empty,
  output logic [31:0]            stat_timeouts
`endif
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // READ  | popping the FIFO until the burst ends or the empty-retry limit hits
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RW = $clog2(MAX_EMPTY_RETRY + 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [BURST_WIDTH-1:0] remaining;
  logic                   inject;
  logic [RW-1:0]          retry;
  logic                   space;
  logic                   last_word;
  logic                   retry_final;
  logic                   empty_hit;

  assign space       = !out_valid || out_ready;
  assign last_word   = (remaining == BURST_WIDTH'(1));
  assign retry_final = (retry == RW'(MAX_EMPTY_RETRY - 1));

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rinc      = 1'b0;
    done      = 1'b0;
    empty_hit = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : READ;
      end
      READ: begin
        if (space) begin
          if (inject || !rempty) begin
            rinc = 1'b1;
            if (last_word) state_nxt = DONE;
          end else begin
            empty_hit = 1'b1;
            if (retry_final) state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      remaining <= '0;
      inject    <= 1'b0;
      retry     <= '0;
      status    <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        remaining <= cmd_len;
        inject    <= cmd_inject;
        retry     <= '0;
        status    <= 2'b00;
      end
      // A pop in the same cycle as a consume replaces the word, keeping full throughput.
      if (rinc) begin
        out_data  <= rdata;
        out_valid <= 1'b1;
        out_last  <= last_word;
        remaining <= remaining - BURST_WIDTH'(1);
        retry     <= '0;
        if (inject && rempty) status <= 2'b10;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (empty_hit) begin
        if (retry_final) status <= 2'b01;
        else             retry  <= retry + RW'(1);
      end
    end
  end

`ifdef AFIFO_RD_STATS_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      stat_words    <= '0;
      stat_empty    <= '0;
      stat_timeouts <= '0;
    end else begin
      if (rinc && stat_words != '1) stat_words <= stat_words + 32'd1;
      if (empty_hit && stat_empty != '1) stat_empty <= stat_empty + 32'd1;
      if (empty_hit && retry_final && stat_timeouts != '1)
        stat_timeouts <= stat_timeouts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_afifo_rd_master.sv
// Bench for afifo_rd_master: cycle-level behavioural model with a word scoreboard plus directed
// scenarios with hand-computed expectations; stats checks appear when AFIFO_RD_STATS_EN is defined.
module tb_afifo_rd_master;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int MAXR = 10;
  localparam int PH_IDLE = 0;
  localparam int PH_READ = 1;
  localparam int PH_DONE = 2;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_inject = 1'b0;
  logic          rempty = 1'b1;
  logic          out_ready = 1'b1;
  logic [BW-1:0] cmd_len = '0;
  logic [DW-1:0] rdata = '0;
  logic          cmd_ready, rinc, out_valid, out_last, done;
  logic [DW-1:0] out_data;
  logic [1:0]    status;
`ifdef AFIFO_RD_STATS_EN
  logic [31:0]   stat_words, stat_empty, stat_timeouts;
`endif

  afifo_rd_master #(.DATA_WIDTH(DW), .BURST_WIDTH(BW), .MAX_EMPTY_RETRY(MAXR)) dut (
    .rclk(rclk), .rrst(rrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_inject(cmd_inject),
    .rinc(rinc), .rempty(rempty), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .status(status)
`ifdef AFIFO_RD_STATS_EN
    , .stat_words(stat_words), .stat_empty(stat_empty), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 rclk = ~rclk;

  typedef struct packed {logic [31:0] d; logic last;} word_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model of the command in flight and of the words popped but not yet consumed
  int          ph, m_left, m_empties;
  bit          m_inj;
  logic [1:0]  m_status;
  int          m_words, m_empty_cnt, m_timeouts;
  word_t       exp_q[$];

  // observations for directed checks
  int          acc_cyc, done_cyc, rinc_cnt, first_rinc, last_cnt, last_idx, bp_rinc, fifo_pops;
  logic [31:0] got_q[$];

  int empty_mode, empty_pct, ready_mode, data_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE; m_left = 0; m_empties = 0; m_inj = 0; m_status = 2'b00;
    m_words = 0; m_empty_cnt = 0; m_timeouts = 0;
    exp_q.delete();
  endtask

  task automatic drive_dyn();
    case (empty_mode)
      0:       rempty = 1'b0;
      1:       rempty = 1'b1;
      default: rempty = ($urandom_range(0, 99) < empty_pct);
    endcase
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = !(acc_cyc >= 0 && cyc - acc_cyc >= 2 && cyc - acc_cyc <= 6);
    endcase
    rdata = (data_mode == 0) ? 32'hA0 + 32'(fifo_pops) : $urandom;
  endtask

  // Called at a falling edge with inputs applied; checks, then advances the model over the rising edge.
  task automatic step();
    bit    e_space, e_pop, e_empty;
    int    old;
    word_t w;
    #1;
    e_space = (exp_q.size() == 0) || out_ready;
    e_pop   = (ph == PH_READ) && e_space && (m_inj || !rempty);
    e_empty = (ph == PH_READ) && e_space && rempty && !m_inj;
    chk("cmd_ready", 32'(cmd_ready), 32'(ph == PH_IDLE));
    chk("rinc", 32'(rinc), 32'(e_pop));
    chk("done", 32'(done), 32'(ph == PH_DONE));
    chk("status", 32'(status), 32'(m_status));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_data", out_data, exp_q[0].d);
      chk("out_last", 32'(out_last), 32'(exp_q[0].last));
    end
`ifdef AFIFO_RD_STATS_EN
    chk("stat_words", stat_words, 32'(m_words));
    chk("stat_empty", stat_empty, 32'(m_empty_cnt));
    chk("stat_timeouts", stat_timeouts, 32'(m_timeouts));
`endif
    if (rinc) begin
      rinc_cnt++;
      fifo_pops++;
      if (first_rinc < 0) first_rinc = cyc;
      if (acc_cyc >= 0 && cyc - acc_cyc >= 2 && cyc - acc_cyc <= 6) bp_rinc++;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      if (out_last) begin last_cnt++; last_idx = got_q.size() - 1; end
    end

    old = ph;
    if (exp_q.size() != 0 && out_ready) exp_q.delete(0);
    if (e_pop) begin
      w.d = rdata;
      w.last = (m_left == 1);
      exp_q.push_back(w);
      m_left--; m_empties = 0; m_words++;
      if (m_inj && rempty) m_status = 2'b10;
      if (m_left == 0) ph = PH_DONE;
    end else if (e_empty) begin
      m_empties++; m_empty_cnt++;
      if (m_empties == MAXR) begin m_status = 2'b01; m_timeouts++; ph = PH_DONE; end
    end
    if (old == PH_IDLE && cmd_valid) begin
      m_left = int'(cmd_len); m_inj = cmd_inject; m_empties = 0; m_status = 2'b00;
      ph = (cmd_len == '0) ? PH_DONE : PH_READ;
      if (acc_cyc < 0) acc_cyc = cyc;
    end
    if (old == PH_DONE) ph = PH_IDLE;
    @(posedge rclk);
    cyc++;
    @(negedge rclk);
  endtask

  task automatic clear_obs();
    acc_cyc = -1; done_cyc = -1; rinc_cnt = 0; first_rinc = -1; last_cnt = 0; last_idx = -1;
    bp_rinc = 0; fifo_pops = 0;
    got_q.delete();
  endtask

  task automatic run_cmd(input int len, input bit inj, input int budget);
    int n;
    clear_obs();
    cmd_valid = 1'b1; cmd_len = BW'(len); cmd_inject = inj;
    n = 0;
    while (!(done_cyc >= 0 && exp_q.size() == 0 && ph == PH_IDLE) && n < budget) begin
      drive_dyn();
      step();
      if (acc_cyc >= 0) begin cmd_valid = 1'b0; cmd_inject = 1'b0; end
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL cmd_budget: got %0d cycles want fewer than %0d", n, budget);
    end
  endtask

  initial begin
    int pct_tab[4];
    pct_tab[0] = 0; pct_tab[1] = 30; pct_tab[2] = 70; pct_tab[3] = 100;
    model_reset();
    clear_obs();
    empty_mode = 0; empty_pct = 0; ready_mode = 0; data_mode = 0;

    @(negedge rclk); #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    @(negedge rclk);
    rrst = 1'b0;

    // basic burst
    empty_mode = 0; ready_mode = 0; data_mode = 0;
    run_cmd(4, 0, 30);
    chk("basic_first_rinc_ofs", 32'(first_rinc - acc_cyc), 32'd1);
    chk("basic_rinc_cnt", 32'(rinc_cnt), 32'd4);
    chk("basic_done_ofs", 32'(done_cyc - acc_cyc), 32'd5);
    chk("basic_words", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("basic_word", got_q[i], 32'hA0 + 32'(i));
    chk("basic_last_idx", 32'(last_idx), 32'd3);
    chk("basic_last_cnt", 32'(last_cnt), 32'd1);
    chk("basic_status", 32'(status), 32'd0);

    // timeout
    empty_mode = 1;
    run_cmd(3, 0, 40);
    chk("to_rinc_cnt", 32'(rinc_cnt), 32'd0);
    chk("to_done_ofs", 32'(done_cyc - acc_cyc), 32'd11);
    chk("to_status", 32'(status), 32'd1);
    chk("to_last_cnt", 32'(last_cnt), 32'd0);
`ifdef AFIFO_RD_STATS_EN
    chk("stats_words", stat_words, 32'd4);
    chk("stats_empty", stat_empty, 32'd10);
    chk("stats_timeouts", stat_timeouts, 32'd1);
`endif

    // backpressure
    empty_mode = 0; ready_mode = 2;
    run_cmd(3, 0, 40);
    chk("bp_rinc_in_stall", 32'(bp_rinc), 32'd0);
    chk("bp_rinc_cnt", 32'(rinc_cnt), 32'd3);
    chk("bp_done_ofs", 32'(done_cyc - acc_cyc), 32'd9);
    chk("bp_words", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("bp_word", got_q[i], 32'hA0 + 32'(i));
    chk("bp_status", 32'(status), 32'd0);

    // underflow injection
    empty_mode = 1; ready_mode = 0;
    run_cmd(2, 1, 20);
    chk("inj_rinc_cnt", 32'(rinc_cnt), 32'd2);
    chk("inj_done_ofs", 32'(done_cyc - acc_cyc), 32'd3);
    chk("inj_status", 32'(status), 32'd2);
    chk("inj_last_cnt", 32'(last_cnt), 32'd1);

    // reset mid-burst, then zero length
    empty_mode = 0; ready_mode = 0;
    clear_obs();
    cmd_valid = 1'b1; cmd_len = BW'(8); cmd_inject = 1'b0;
    for (int n = 0; n < 20 && rinc_cnt < 3; n++) begin
      drive_dyn();
      step();
      if (acc_cyc >= 0) cmd_valid = 1'b0;
    end
    chk("mid_pops_before_rst", 32'(rinc_cnt), 32'd3);
    rrst = 1'b1;
    #1;
    chk("mid_rst_rinc", 32'(rinc), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    model_reset();
    cmd_valid = 1'b0;
    repeat (2) @(negedge rclk);
    cyc += 2;
    rrst = 1'b0;
    run_cmd(0, 0, 10);
    chk("zero_rinc_cnt", 32'(rinc_cnt), 32'd0);
    chk("zero_done_ofs", 32'(done_cyc - acc_cyc), 32'd1);
    chk("zero_status", 32'(status), 32'd0);

    // randomized traffic against the model
    empty_mode = 2; ready_mode = 1; data_mode = 1;
    clear_obs();
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) empty_pct = pct_tab[$urandom_range(0, 3)];
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_len    = ($urandom_range(0, 7) == 0) ? BW'(0) : BW'($urandom_range(1, 12));
      cmd_inject = ($urandom_range(0, 7) == 0);
      drive_dyn();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/afifo_rd_master.md
# afifo_rd_master

Synthesisable, parametrised read-side master for the asynchronous FIFO, living entirely in the read clock domain. It accepts burst read commands, pops the FIFO read port with empty-retry timeout and optional underflow injection, and delivers words on a valid/ready stream with a burst-last marker. It is the RTL successor of the single-word bench read driver, adding burst length, backpressure, per-command status and optional statistics.

## Interface
- DATA_WIDTH, 32: FIFO and stream data width.
- BURST_WIDTH, 8: width of cmd_len; maximum burst is 2^BURST_WIDTH-1 words.
- MAX_EMPTY_RETRY, 10: consecutive eligible empty cycles before timeout; must be ≥1.

Ports. One clock; reset is asynchronous and active-high.
- rclk  in  1  read-domain clock.
- rrst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  BURST_WIDTH  words to read.
- cmd_inject  in  1  underflow injection: pop regardless of rempty.
- rinc  out  1  FIFO pop, combinational.
- rempty  in  1  FIFO empty.
- rdata  in  DATA_WIDTH  FIFO head word, show-ahead.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream sink ready.
- out_data  out  DATA_WIDTH  stream word.
- out_last  out  1  final word of a burst.
- done  out  1  one-cycle command-complete pulse.
- status  out  2  00 OK, 01 TIMEOUT, 10 UNDERFLOW; held until the next command is accepted.

## Operation
- Reset values: state IDLE, cmd_ready 1, rinc 0, out_valid 0, out_data 0, out_last 0, done 0, status 00, internal counters 0. Reset acts asynchronously mid-burst; any pending output word is discarded.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch remaining=cmd_len, inject=cmd_inject, and clear retry and status. Go to DONE if cmd_len==0, else to READ.
  - READ: space = !out_valid || out_ready.
    - Normal pop: rinc = space && !rempty && !inject.
    - Inject pop: rinc = space && inject.
    - Each pop loads out_data<=rdata and sets out_valid, decrements remaining and clears retry.
    - If an inject pop occurs while rempty=1, status<=10 (sticky for the command).
    - When remaining reaches 0 on a pop, set out_last on that word and go to DONE.
  - Retry counter, width $clog2(MAX_EMPTY_RETRY+1):
    - Increments on each eligible empty cycle: READ && space && rempty && !inject.
    - Holds during backpressure (!space).
    - If an increment would reach MAX_EMPTY_RETRY: status<=01, go to DONE, no pop, no out_last.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Output register: out_valid clears on out_ready when no new pop occurs the same cycle. Pop and consume in the same cycle replaces the word, giving full throughput. out_last clears with its word.
- A pending output word may still be valid when done pulses. It drains normally through IDLE.
- cmd_len is unsigned; remaining never wraps.

## Timing
- Command accepted in cycle N; earliest rinc in N+1; first out_valid in N+2.
- Steady state: one word per cycle while !rempty and out_ready=1.
- Last pop in cycle M; done in M+1; cmd_ready in M+2.
- Timeout: MAX_EMPTY_RETRY consecutive eligible empty cycles in READ, then done on the following cycle.
- rinc depends combinationally on rempty and out_ready; it is never high outside READ.

## Configuration
- AFIFO_RD_STATS_EN defined: adds three 32-bit saturating output counters, each reset to 0 by rrst only:
  - stat_words: pops.
  - stat_empty: eligible empty cycles.
  - stat_timeouts: TIMEOUT completions.
- AFIFO_RD_STATS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Basic burst: cmd_len=4, rdata=0xA0..0xA3, rempty=0, out_ready=1 -> rinc high 4 consecutive cycles from N+1; stream words A0..A3 with out_last on A3; done one cycle after the last pop; status 00.
- Timeout: MAX_EMPTY_RETRY=10, rempty held 1, cmd_len=3 -> accept in cycle 0; rinc never high; done in cycle 11; status 01; no out_last.
- Backpressure: cmd_len=3, out_ready=0 for 5 cycles after the first word -> exactly one pop, then rinc low; retry counter does not advance; 3 words delivered in order after release.
- Underflow injection: cmd_inject=1, rempty=1, cmd_len=2 -> 2 pops on consecutive cycles; status 10; done pulses.
- Reset and zero length: rrst asserted mid-burst of 8 -> rinc, out_valid and done drop immediately; cmd_ready=1 after release. A following cmd_len=0 -> no rinc; done in the next cycle; status 00.
- Stats (AFIFO_RD_STATS_EN defined): basic burst followed by the timeout case -> stat_words=4, stat_empty=10, stat_timeouts=1.
